// File: rtl/bus_responder.sv
// bus_responder: memory-side responder for the S1C88 external bus.
// Decodes the Pokemon Mini address map and performs the access against the
// BIOS ROM, internal RAM, I/O register port, cartridge handshake or the
// interrupt-vector fetch. Read data is returned on data_out. Cartridge cycles
// are stretched with bus_wait.
//
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   pk                   core phase clock (pk==0 at a rising edge = issue edge)
//   address_in, wdata    core address / write data
//   bus_status           0 idle, 1 IRQ read, 2 mem write, 3 mem read
//   read, write, iack    core strobes
//   irq_vector           vector byte returned on an IRQ read
//   rom_addr, rom_data   combinational BIOS ROM port
//   io_*                 I/O register port (one-clock io_we / io_re pulses)
//   cart_*               cartridge request/acknowledge handshake
//   data_out             read data to the core
//   bus_wait             stretches the core while a cartridge cycle is open
//   bus_error            sticky cartridge timeout flag
module bus_responder #(
  parameter int RAM_AW       = 12,
  parameter int CART_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pk,
  input  logic [23:0] address_in,
  input  logic [7:0]  wdata,
  input  logic [1:0]  bus_status,
  input  logic        read,
  input  logic        write,
  input  logic        iack,
  input  logic [7:0]  irq_vector,
  output logic [11:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic [7:0]  io_addr,
  output logic [7:0]  io_wdata,
  output logic        io_we,
  output logic        io_re,
  input  logic [7:0]  io_rdata,
  output logic [20:0] cart_addr,
  output logic [7:0]  cart_wdata,
  output logic        cart_req,
  output logic        cart_we,
  input  logic        cart_ack,
  input  logic [7:0]  cart_rdata,
  output logic [7:0]  data_out,
  output logic        bus_wait,
  output logic        bus_error
);

  localparam int RAM_DEPTH = 1 << RAM_AW;
  localparam int CW        = $clog2(CART_TIMEOUT + 1);
  // Counter value at the edge where the last allowed wait clock expires.
  localparam logic [CW-1:0] TO_LAST = CW'(CART_TIMEOUT - 1);

  typedef enum logic [0:0] {
    ST_IDLE      = 1'b0,
    ST_CART_WAIT = 1'b1
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic [7:0]    ram_r [0:RAM_DEPTH-1];

  logic        issue_s, rd_s, wr_s, irq_s, timeout_s;
  logic        rom_hit_s, ram_hit_s, io_hit_s, cart_hit_s;
  logic [7:0]  data_nxt_s, io_addr_nxt_s, io_wdata_nxt_s, cart_wdata_nxt_s;
  logic [20:0] cart_addr_nxt_s;
  logic        io_we_nxt_s, io_re_nxt_s, cart_req_nxt_s, cart_we_nxt_s;
  logic        bus_wait_nxt_s, bus_error_nxt_s;

  assign rom_addr = address_in[11:0];

  // Accesses are only accepted on pk==0 edges while no cartridge cycle is open;
  // bus_status alone selects the direction when both strobes are high.
  assign issue_s = (state_r == ST_IDLE) && !pk;
  assign rd_s    = issue_s && (bus_status == 2'd3) && read;
  assign wr_s    = issue_s && (bus_status == 2'd2) && write;
  assign irq_s   = issue_s && (bus_status == 2'd1) && iack;

  assign rom_hit_s  = (address_in <  24'h001000);
  assign ram_hit_s  = (address_in >= 24'h001000) && (address_in < 24'h002000);
  assign io_hit_s   = (address_in >= 24'h002000) && (address_in < 24'h002100);
  assign cart_hit_s = (address_in >= 24'h002100) && (address_in <= 24'h1FFFFF);
  assign timeout_s  = (cnt_r >= TO_LAST);

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_nxt_s;
  end

  // FSM next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if ((rd_s || wr_s) && cart_hit_s) state_nxt_s = ST_CART_WAIT;
        else                              state_nxt_s = ST_IDLE;
      end
      ST_CART_WAIT: begin
        if (cart_ack || timeout_s) state_nxt_s = ST_IDLE;
        else                       state_nxt_s = ST_CART_WAIT;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of every registered output, derived from state and inputs
  always_comb begin
    data_nxt_s       = data_out;
    io_addr_nxt_s    = io_addr;
    io_wdata_nxt_s   = io_wdata;
    io_we_nxt_s      = 1'b0;
    io_re_nxt_s      = 1'b0;
    cart_addr_nxt_s  = cart_addr;
    cart_wdata_nxt_s = cart_wdata;
    cart_req_nxt_s   = cart_req;
    cart_we_nxt_s    = cart_we;
    bus_wait_nxt_s   = bus_wait;
    bus_error_nxt_s  = bus_error;
    cnt_nxt_s        = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (irq_s) begin
          data_nxt_s = irq_vector;
        end else if (rd_s) begin
          if (rom_hit_s) begin
            data_nxt_s = rom_data;
          end else if (ram_hit_s) begin
            data_nxt_s = ram_r[address_in[RAM_AW-1:0]];
          end else if (io_hit_s) begin
            data_nxt_s    = io_rdata;
            io_re_nxt_s   = 1'b1;
            io_addr_nxt_s = address_in[7:0];
          end else if (cart_hit_s) begin
            cart_req_nxt_s  = 1'b1;
            cart_we_nxt_s   = 1'b0;
            cart_addr_nxt_s = address_in[20:0];
            bus_wait_nxt_s  = 1'b1;
            cnt_nxt_s       = '0;
          end else begin
            data_nxt_s = 8'hFF;  // open bus
          end
        end else if (wr_s) begin
          if (io_hit_s) begin
            io_we_nxt_s    = 1'b1;
            io_addr_nxt_s  = address_in[7:0];
            io_wdata_nxt_s = wdata;
          end else if (cart_hit_s) begin
            cart_req_nxt_s   = 1'b1;
            cart_we_nxt_s    = 1'b1;
            cart_addr_nxt_s  = address_in[20:0];
            cart_wdata_nxt_s = wdata;
            bus_wait_nxt_s   = 1'b1;
            cnt_nxt_s        = '0;
          end else begin
            // ROM and open-bus writes are dropped; RAM commits in its own block
            data_nxt_s = data_out;
          end
        end else begin
          data_nxt_s = data_out;
        end
      end
      ST_CART_WAIT: begin
        if (cart_ack) begin
          if (!cart_we) data_nxt_s = cart_rdata;
          else          data_nxt_s = data_out;
          cart_req_nxt_s = 1'b0;
          bus_wait_nxt_s = 1'b0;
        end else if (timeout_s) begin
          if (!cart_we) data_nxt_s = 8'hFF;
          else          data_nxt_s = data_out;
          bus_error_nxt_s = 1'b1;
          cart_req_nxt_s  = 1'b0;
          bus_wait_nxt_s  = 1'b0;
        end else begin
          cnt_nxt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        cart_req_nxt_s = 1'b0;
        bus_wait_nxt_s = 1'b0;
      end
    endcase
  end

  // Output and timeout-counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out   <= 8'hFF;
      io_addr    <= 8'h00;
      io_wdata   <= 8'h00;
      io_we      <= 1'b0;
      io_re      <= 1'b0;
      cart_addr  <= 21'h000000;
      cart_wdata <= 8'h00;
      cart_req   <= 1'b0;
      cart_we    <= 1'b0;
      bus_wait   <= 1'b0;
      bus_error  <= 1'b0;
      cnt_r      <= '0;
    end else begin
      data_out   <= data_nxt_s;
      io_addr    <= io_addr_nxt_s;
      io_wdata   <= io_wdata_nxt_s;
      io_we      <= io_we_nxt_s;
      io_re      <= io_re_nxt_s;
      cart_addr  <= cart_addr_nxt_s;
      cart_wdata <= cart_wdata_nxt_s;
      cart_req   <= cart_req_nxt_s;
      cart_we    <= cart_we_nxt_s;
      bus_wait   <= bus_wait_nxt_s;
      bus_error  <= bus_error_nxt_s;
      cnt_r      <= cnt_nxt_s;
    end
  end

  // Internal RAM write port; contents are intentionally left unreset
  always_ff @(posedge clk) begin
    if (!reset && wr_s && ram_hit_s) ram_r[address_in[RAM_AW-1:0]] <= wdata;
  end

endmodule

// File: tb/tb_bus_responder.sv
// Self-checking bench for bus_responder. Expected read data is pushed into a
// scoreboard queue when a read is driven and popped when the DUT returns it.
module tb_bus_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pk = 1'b1;
  logic [23:0] address_in = 24'h000000;
  logic [7:0]  wdata = 8'h00;
  logic [1:0]  bus_status = 2'd0;
  logic        read = 1'b0, write = 1'b0, iack = 1'b0;
  logic [7:0]  irq_vector = 8'h00;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data;
  logic [7:0]  io_addr, io_wdata;
  logic        io_we, io_re;
  logic [7:0]  io_rdata = 8'h00;
  logic [20:0] cart_addr;
  logic [7:0]  cart_wdata;
  logic        cart_req, cart_we;
  logic        cart_ack = 1'b0;
  logic [7:0]  cart_rdata = 8'h00;
  logic [7:0]  data_out;
  logic        bus_wait, bus_error;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] sb_q [$];

  // ROM model: byte = low address byte + 0x4A (0x010 -> 0x5A, 0x020 -> 0x6A)
  assign rom_data = rom_addr[7:0] + 8'h4A;

  bus_responder #(.RAM_AW(12), .CART_TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .pk(pk), .address_in(address_in), .wdata(wdata),
    .bus_status(bus_status), .read(read), .write(write), .iack(iack),
    .irq_vector(irq_vector), .rom_addr(rom_addr), .rom_data(rom_data),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_we(io_we), .io_re(io_re),
    .io_rdata(io_rdata), .cart_addr(cart_addr), .cart_wdata(cart_wdata),
    .cart_req(cart_req), .cart_we(cart_we), .cart_ack(cart_ack),
    .cart_rdata(cart_rdata), .data_out(data_out), .bus_wait(bus_wait),
    .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  initial begin
    #60000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag);
    logic [7:0] e;
    check_val({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_val(tag, 32'(data_out), 32'(e));
    end
  endtask

  // One bus access: issued on the next pk==0 edge; returns #1 after that edge.
  task automatic do_access(input logic [1:0] st, input logic rd, input logic wr,
                           input logic ik, input logic [23:0] a, input logic [7:0] d);
    @(negedge clk);
    pk = 1'b0; bus_status = st; read = rd; write = wr; iack = ik;
    address_in = a; wdata = d;
    @(posedge clk); #1;
    pk = 1'b1; bus_status = 2'd0; read = 1'b0; write = 1'b0; iack = 1'b0;
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  // Cartridge access acknowledged on the delay-th CART_WAIT edge.
  task automatic cart_xfer(input string tag, input logic is_wr, input logic [23:0] a,
                           input logic [7:0] d, input int delay, input logic [7:0] ack_data,
                           input logic [7:0] hold_data);
    int hi;
    if (!is_wr) sb_q.push_back(ack_data);
    do_access(is_wr ? 2'd2 : 2'd3, !is_wr, is_wr, 1'b0, a, d);
    check_val({tag, "_req"}, 32'(cart_req), 32'd1);
    check_val({tag, "_we"}, 32'(cart_we), 32'(is_wr));
    check_val({tag, "_addr"}, 32'(cart_addr), 32'(a[20:0]));
    if (is_wr) check_val({tag, "_wdata"}, 32'(cart_wdata), 32'(d));
    hi = bus_wait ? 1 : 0;
    for (int i = 1; i < delay; i++) begin
      step();
      if (bus_wait) hi++;
    end
    @(negedge clk);
    cart_ack = 1'b1; cart_rdata = ack_data;
    step();
    cart_ack = 1'b0; cart_rdata = 8'h00;
    check_val({tag, "_wait_len"}, 32'(hi), 32'(delay));
    check_val({tag, "_wait_end"}, 32'(bus_wait), 32'd0);
    check_val({tag, "_req_end"}, 32'(cart_req), 32'd0);
    check_val({tag, "_err"}, 32'(bus_error), 32'd0);
    if (is_wr) check_val({tag, "_hold"}, 32'(data_out), 32'(hold_data));
    else       sb_check(tag);
  endtask

  initial begin
    int cnt;
    // Reset
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_val("rst_data", 32'(data_out), 32'hFF);
    check_val("rst_wait", 32'(bus_wait), 32'd0);
    check_val("rst_req", 32'(cart_req), 32'd0);
    check_val("rst_cwe", 32'(cart_we), 32'd0);
    check_val("rst_iowe", 32'(io_we), 32'd0);
    check_val("rst_iore", 32'(io_re), 32'd0);
    check_val("rst_err", 32'(bus_error), 32'd0);
    check_val("rst_caddr", 32'(cart_addr), 32'd0);
    check_val("rst_ioaddr", 32'(io_addr), 32'd0);

    // ROM read
    sb_q.push_back(8'h5A);
    do_access(2'd3, 1'b1, 1'b0, 1'b0, 24'h000010, 8'h00);
    sb_check("rom_rd");
    check_val("rom_wait", 32'(bus_wait), 32'd0);

    // RAM write/read at the top RAM address
    do_access(2'd2, 1'b0, 1'b1, 1'b0, 24'h001FFF, 8'hA5);
    sb_q.push_back(8'hA5);
    do_access(2'd3, 1'b1, 1'b0, 1'b0, 24'h001FFF, 8'h00);
    sb_check("ram_rd");

    // ROM write is ignored
    do_access(2'd2, 1'b0, 1'b1, 1'b0, 24'h000020, 8'h33);
    sb_q.push_back(8'h6A);
    do_access(2'd3, 1'b1, 1'b0, 1'b0, 24'h000020, 8'h00);
    sb_check("rom_wr_ign");

    // Both strobes high: bus_status picks the direction
    do_access(2'd2, 1'b1, 1'b1, 1'b0, 24'h001000, 8'h3C);
    sb_q.push_back(8'h3C);
    do_access(2'd3, 1'b1, 1'b1, 1'b0, 24'h001000, 8'h55);
    sb_check("both_strobes");

    // I/O write pulse
    do_access(2'd2, 1'b0, 1'b1, 1'b0, 24'h002080, 8'h12);
    check_val("io_we", 32'(io_we), 32'd1);
    check_val("io_waddr", 32'(io_addr), 32'h80);
    check_val("io_wdata", 32'(io_wdata), 32'h12);
    step();
    check_val("io_we_end", 32'(io_we), 32'd0);

    // I/O read
    io_rdata = 8'h77;
    sb_q.push_back(8'h77);
    do_access(2'd3, 1'b1, 1'b0, 1'b0, 24'h002081, 8'h00);
    check_val("io_re", 32'(io_re), 32'd1);
    check_val("io_raddr", 32'(io_addr), 32'h81);
    sb_check("io_rd");
    step();
    check_val("io_re_end", 32'(io_re), 32'd0);

    // pk==1 edge never issues
    io_rdata = 8'h11;
    @(negedge clk);
    pk = 1'b1; bus_status = 2'd3; read = 1'b1; address_in = 24'h002081;
    step();
    bus_status = 2'd0; read = 1'b0;
    check_val("pk1_iore", 32'(io_re), 32'd0);
    check_val("pk1_hold", 32'(data_out), 32'h77);

    // Cartridge read, ack on the 5th wait edge
    cart_xfer("cart_rd", 1'b0, 24'h123456, 8'h00, 5, 8'hC3, 8'h00);
    // Cartridge write at the top cartridge address, minimum stretch
    cart_xfer("cart_wr", 1'b1, 24'h1FFFFF, 8'h9E, 1, 8'h00, 8'hC3);

    // Stray ack in IDLE is ignored
    @(negedge clk); cart_ack = 1'b1;
    step(); cart_ack = 1'b0;
    check_val("stray_ack_wait", 32'(bus_wait), 32'd0);
    check_val("stray_ack_data", 32'(data_out), 32'hC3);

    // Cartridge timeout at the lowest cartridge address
    sb_q.push_back(8'hFF);
    do_access(2'd3, 1'b1, 1'b0, 1'b0, 24'h002100, 8'h00);
    check_val("to_addr", 32'(cart_addr), 32'h002100);
    cnt = 0;
    while (bus_wait && cnt < 400) begin
      cnt++;
      step();
    end
    check_val("to_len", 32'(cnt), 32'd255);
    check_val("to_req", 32'(cart_req), 32'd0);
    check_val("to_err", 32'(bus_error), 32'd1);
    sb_check("to_data");

    // bus_error is sticky across later accesses
    sb_q.push_back(8'h5A);
    do_access(2'd3, 1'b1, 1'b0, 1'b0, 24'h000010, 8'h00);
    sb_check("rom_rd2");
    check_val("err_sticky", 32'(bus_error), 32'd1);

    // IRQ vector read, address ignored
    irq_vector = 8'h06;
    sb_q.push_back(8'h06);
    do_access(2'd1, 1'b0, 1'b0, 1'b1, 24'h001FFF, 8'h00);
    sb_check("irq_rd");

    // bus_status 0 with read high: no access
    do_access(2'd0, 1'b1, 1'b0, 1'b0, 24'h000010, 8'h00);
    check_val("idle_hold", 32'(data_out), 32'h06);

    // Open bus
    sb_q.push_back(8'hFF);
    do_access(2'd3, 1'b1, 1'b0, 1'b0, 24'h300000, 8'h00);
    sb_check("open_rd");

    // Reset in the middle of a cartridge wait
    do_access(2'd3, 1'b1, 1'b0, 1'b0, 24'h040000, 8'h00);
    check_val("mid_wait_on", 32'(bus_wait), 32'd1);
    repeat (9) step();
    @(negedge clk); reset = 1'b1;
    step();
    check_val("mid_rst_req", 32'(cart_req), 32'd0);
    check_val("mid_rst_wait", 32'(bus_wait), 32'd0);
    check_val("mid_rst_err", 32'(bus_error), 32'd0);
    check_val("mid_rst_data", 32'(data_out), 32'hFF);
    @(negedge clk); reset = 1'b0;

    // FSM back in IDLE: a fresh access completes immediately
    sb_q.push_back(8'h6A);
    do_access(2'd3, 1'b1, 1'b0, 1'b0, 24'h000020, 8'h00);
    sb_check("post_rst_rd");

    check_val("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bus_responder.md
# bus_responder

Memory-side responder for the S1C88 core's external bus. It samples the core's address, status and strobes, decodes the Pokémon Mini address map, and performs the access: BIOS ROM, internal RAM, I/O register file, cartridge, or interrupt-vector fetch. It returns read data on the core's `data_in` and stretches cartridge cycles with `bus_wait`. It sits between the core and the memory/peripheral blocks in the system top level.

## Interface
- `RAM_AW`, default 12: internal RAM address width (4 KiB).
- `CART_TIMEOUT`, default 255: maximum clocks to wait for `cart_ack`.
- `clk` in 1: system clock. All logic is on the rising edge.
- `reset` in 1: **one clock; reset is synchronous and active-high**.
- `pk` in 1: core phase clock; `pk==0` at a rising edge marks the access-issue edge.
- `address_in` in 24: core `address_out`.
- `wdata` in 8: core `data_out`.
- `bus_status` in 2: 0 idle, 1 IRQ read, 2 mem write, 3 mem read.
- `read`, `write`, `iack` in 1 each: core strobes.
- `irq_vector` in 8: vector byte returned on IRQ read.
- `rom_addr` out 12: `address_in[11:0]`, combinational.
- `rom_data` in 8: combinational-read BIOS ROM.
- `io_addr` out 8, `io_wdata` out 8, `io_we` out 1, `io_re` out 1, `io_rdata` in 8: I/O register port.
- `cart_addr` out 21, `cart_wdata` out 8, `cart_req` out 1, `cart_we` out 1, `cart_ack` in 1, `cart_rdata` in 8: cartridge handshake.
- `data_out` out 8: read data to the core's `data_in`.
- `bus_wait` out 1: core holds the `pk==1` edge (no latch, no toggle) while high.
- `bus_error` out 1: sticky cartridge timeout flag.

## Operation
- Address map (`address_in`):
  - 0x000000–0x000FFF: ROM. Read only; writes are ignored.
  - 0x001000–0x001FFF: RAM.
  - 0x002000–0x0020FF: I/O.
  - 0x002100–0x1FFFFF: cartridge, `cart_addr = address_in[20:0]`.
  - Above 0x1FFFFF: open bus. Reads return 0xFF; writes are ignored.
- An access is issued at a rising edge with `pk==0` while in IDLE:
  - Read: `bus_status==3 && read`.
  - Write: `bus_status==2 && write`.
  - IRQ read: `bus_status==1 && iack`. `data_out <= irq_vector`; the address is ignored.
  - Any other combination is no access; `data_out` holds.
- Rising edges with `pk==1` never issue an access.
- ROM, RAM, I/O and open bus complete on the issue edge:
  - Reads register `data_out` on that edge.
  - RAM writes commit on that edge.
  - I/O: `io_we`/`io_re` are single-clock pulses on the clock after issue, with `io_addr`/`io_wdata` registered. `io_rdata` is sampled combinationally at the issue edge into `data_out`.
- Cartridge FSM states: IDLE, CART_WAIT.
  - IDLE → CART_WAIT on a cartridge access. At that edge: `cart_req<=1`, `cart_we` per direction, `cart_addr`/`cart_wdata` registered, `bus_wait<=1`, timeout counter cleared.
  - CART_WAIT, `cart_ack` high → IDLE. At that edge: `data_out<=cart_rdata` (reads only), `cart_req<=0`, `bus_wait<=0`.
  - CART_WAIT, counter reaches `CART_TIMEOUT` with no ack → IDLE. At that edge: `data_out<=0xFF` (reads), `bus_error<=1`, `cart_req<=0`, `bus_wait<=0`.
  - `cart_ack` seen while in IDLE is ignored.
- `bus_error` clears only on reset.
- Simultaneous `read` and `write` with a matching `bus_status`: `bus_status` decides the direction.

## Timing
- Reset values: `data_out`=0xFF, `bus_wait`=0, `cart_req`=0, `cart_we`=0, `io_we`=0, `io_re`=0, `bus_error`=0, FSM=IDLE, `cart_addr`/`io_addr`=0. RAM contents are not reset.
- Non-cartridge read latency is 1 clock. Data is valid before the next (`pk==1`) edge, where the core latches it.
- Cartridge read: `bus_wait` high from the issue edge through the ack edge. Core latches on the first `pk==1` edge with `bus_wait==0`. Minimum stretch is 1 clock (ack on the first CART_WAIT edge).
- `cart_req` is held stable until the ack edge. The slave may hold `cart_ack` high for exactly one clock.
- Reset asserted mid-CART_WAIT: on the next edge, return to IDLE with `cart_req`=0 and `bus_wait`=0. No data is returned.

## Test plan
- Reset, then ROM read at 0x000010 with `rom_data`=0x5A → `data_out`=0x5A one clock after the `pk==0` edge; `bus_wait` stays 0.
- RAM write of 0xA5 to 0x001FFF, then read 0x001FFF → read returns 0xA5. Then write 0x33 to 0x000020 (ROM), then read 0x000020 → read returns current `rom_data`; the ROM write had no effect.
- I/O write of 0x12 to 0x002080 → one-clock `io_we` pulse with `io_addr`=0x80, `io_wdata`=0x12. I/O read of 0x002081 with `io_rdata`=0x77 → `io_re` pulse and `data_out`=0x77.
- Cartridge read at 0x123456 with `cart_ack` after 5 clocks and `cart_rdata`=0xC3 → `cart_addr`=0x123456, `bus_wait` high for 5 clocks, `data_out`=0xC3, `bus_error`=0.
- Cartridge read with no ack → after 255 clocks `bus_wait`=0, `data_out`=0xFF, `bus_error`=1. `bus_error` stays 1 until reset. Repeat with reset asserted at clock 10 → `cart_req`=0 and `bus_wait`=0 on the next edge.
- IRQ read (`bus_status`=1, `iack`=1, `irq_vector`=0x06) → `data_out`=0x06. Open-bus read at 0x300000 → `data_out`=0xFF. `bus_status`=0 with `read` high → `data_out` unchanged.
